// File: rtl/multi_digit_7seg_driver_pkg.sv
// Shared constants, FSM encoding and glyph helpers for the multiplexed 7-segment driver.
package multi_digit_7seg_driver_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } conv_state_e;

  // Active-low {a,b,c,d,e,f,g} glyph for one BCD nibble; non-BCD codes are dark.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = 7'b0000001;
      4'd1:    pat = 7'b1001111;
      4'd2:    pat = 7'b0010010;
      4'd3:    pat = 7'b0000110;
      4'd4:    pat = 7'b1001100;
      4'd5:    pat = 7'b0100100;
      4'd6:    pat = 7'b0100000;
      4'd7:    pat = 7'b0001111;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0000100;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

  // Largest value representable on n decimal digits (10^n - 1).
  function automatic logic [31:0] max_dec(input int n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 32'd10;
    end
    return r - 32'd1;
  endfunction

endpackage

// File: rtl/multi_digit_7seg_driver_if.sv
// Load/status channel between the score logic (master) and the display driver (slave).
interface multi_digit_7seg_driver_if #(
  parameter int BIN_W = 14
);
  logic [BIN_W-1:0] bin_in;
  logic             load;
  logic             ready;
  logic             overflow;

  modport master (output bin_in, output load, input ready, input overflow);
  modport slave  (input bin_in, input load, output ready, output overflow);
endinterface

// File: rtl/multi_digit_7seg_driver_bin2bcd_dd.sv
// Serial double-dabble converter: one add-3/shift step per clock, BIN_W steps per value.
module multi_digit_7seg_driver_bin2bcd_dd
  import multi_digit_7seg_driver_pkg::*;
#(
  parameter int BIN_W      = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic [BIN_W-1:0]        bin_i,
  output logic                    ready_o,
  output logic                    done_o,
  output logic [4*NUM_DIGITS-1:0] bcd_o
);
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

  conv_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BCD_W-1:0] adj_s;
  logic [3:0]       nib_s;

  // Add 3 to every nibble that would reach 10 or more after the next shift.
  always_comb begin
    adj_s = '0;
    nib_s = 4'd0;
    for (int n = 0; n < NUM_DIGITS; n++) begin
      nib_s = bcd_q[4*n +: 4];
      adj_s[4*n +: 4] = (nib_s >= 4'd5) ? (nib_s + 4'd3) : nib_s;
    end
  end

  // Conversion FSM next state and shift-register datapath.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    case (state_q)
      ST_IDLE: begin
        if (load_i) begin
          bin_d   = bin_i;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = ST_CONV;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CONV: begin
        bcd_d = {adj_s[BCD_W-2:0], bin_q[BIN_W-1]};
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_CONV;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any conversion in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
    end
  end

  assign ready_o = (state_q == ST_IDLE);
  assign done_o  = (state_q == ST_DONE);
  assign bcd_o   = bcd_q;

endmodule

// File: rtl/multi_digit_7seg_driver.sv
// Time-multiplexed common-anode driver: BCD conversion, overflow dashes, leading-zero blanking.
module multi_digit_7seg_driver
  import multi_digit_7seg_driver_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_LZ   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  multi_digit_7seg_driver_if.slave bus,
  output logic [NUM_DIGITS-1:0]    an,
  output logic [6:0]               seg
);
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam logic [31:0]      MAX_VAL  = max_dec(NUM_DIGITS);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic                  ready_s, done_s, accept_s;
  logic [BCD_W-1:0]      bcd_s;
  logic                  ovf_pend_q, ovf_pend_d;
  logic                  ovf_q, ovf_d;
  logic [BCD_W-1:0]      disp_q, disp_d;
  logic [PRE_W-1:0]      presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] blank_s;
  logic                  seen_nz_s;
  logic [3:0]            nib_s;
  logic                  blank_sel_s;
  logic                  tick_s;

  multi_digit_7seg_driver_bin2bcd_dd #(
    .BIN_W      (BIN_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_conv (
    .clk     (clk),
    .rst     (rst),
    .load_i  (bus.load),
    .bin_i   (bus.bin_in),
    .ready_o (ready_s),
    .done_o  (done_s),
    .bcd_o   (bcd_s)
  );

  assign accept_s     = bus.load & ready_s;
  assign bus.ready    = ready_s;
  assign bus.overflow = ovf_q;

  // Range check at capture; the flag and new digits are published together when conversion ends.
  always_comb begin
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
    disp_d     = disp_q;
    if (accept_s) begin
      ovf_pend_d = (32'(bus.bin_in) > MAX_VAL);
    end else begin
      ovf_pend_d = ovf_pend_q;
    end
    if (done_s) begin
      ovf_d  = ovf_pend_q;
      disp_d = bcd_s;
    end else begin
      ovf_d  = ovf_q;
      disp_d = disp_q;
    end
  end

  // Blank digit i>0 when it and every more significant digit are zero.
  always_comb begin
    blank_s   = '0;
    seen_nz_s = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      seen_nz_s  = seen_nz_s | (disp_q[4*i +: 4] != 4'd0);
      blank_s[i] = (BLANK_LZ != 0) && (i != 0) && !seen_nz_s;
    end
  end

  // Prescaler, digit index and next an/seg; all anodes dark on the cycle the index moves.
  always_comb begin
    nib_s       = 4'd0;
    blank_sel_s = 1'b0;
    an_d        = '1;
    seg_d       = SEG_BLANK;
    tick_s      = (presc_q == PRE_LAST);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == idx_q) begin
        nib_s       = disp_q[4*i +: 4];
        blank_sel_s = blank_s[i];
      end else begin
        an_d[i] = 1'b1;
      end
    end
    if (tick_s) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_LAST) ? '0 : (idx_q + IDX_W'(1));
      an_d    = '1;
      seg_d   = SEG_BLANK;
    end else begin
      presc_d = presc_q + PRE_W'(1);
      idx_d   = idx_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        an_d[i] = (IDX_W'(i) != idx_q);
      end
      if (ovf_q) begin
        seg_d = SEG_DASH;
      end else if (blank_sel_s) begin
        seg_d = SEG_BLANK;
      end else begin
        seg_d = bcd_to_seg(nib_s);
      end
    end
  end

  // Display state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      disp_q     <= '0;
      presc_q    <= '0;
      idx_q      <= '0;
      an_q       <= '1;
      seg_q      <= SEG_BLANK;
    end else begin
      ovf_pend_q <= ovf_pend_d;
      ovf_q      <= ovf_d;
      disp_q     <= disp_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_multi_digit_7seg_driver.sv
// Self-checking bench: table of display values, hand corner cases, random loads vs. an arithmetic model.
module tb_multi_digit_7seg_driver;
  localparam int ND = 4;
  localparam int BW = 14;
  localparam int SD = 4;

  logic clk = 1'b0;
  logic rst;
  logic [ND-1:0] an1, an2;
  logic [6:0]    seg1, seg2;

  always #5 clk = ~clk;

  multi_digit_7seg_driver_if #(.BIN_W(BW)) bus1 ();
  multi_digit_7seg_driver_if #(.BIN_W(BW)) bus2 ();

  multi_digit_7seg_driver #(.NUM_DIGITS(ND), .BIN_W(BW), .SCAN_DIV(SD), .BLANK_LZ(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .an(an1), .seg(seg1));
  multi_digit_7seg_driver #(.NUM_DIGITS(ND), .BIN_W(BW), .SCAN_DIV(SD), .BLANK_LZ(0)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .an(an2), .seg(seg2));

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] glyph [10];

  // reference model state
  int  k, busy, pend_cnt, ovf_cnt, pend_val, shown_val;
  bit  pend_ovf, shown_ovf, ovf_out;
  logic [ND-1:0] prev_an;
  logic [6:0] cap1 [ND];
  logic [6:0] cap2 [ND];

  typedef struct {
    int val;
    bit ovf;
    logic [ND-1:0][6:0] s;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_seg(int val, bit ovf, int i, bit blz);
    int p;
    p = 1;
    for (int j = 0; j < i; j++) p = p * 10;
    if (ovf) return 7'b1111110;
    if (blz && i > 0 && val < p) return 7'b1111111;
    return glyph[(val / p) % 10];
  endfunction

  function automatic logic [ND-1:0] exp_an(int kk);
    logic [ND-1:0] a;
    a = '1;
    if (kk > 0 && ((kk - 1) % SD) != SD - 1) a[((kk - 1) / SD) % ND] = 1'b0;
    return a;
  endfunction

  task automatic set_in(input logic ld, input logic [BW-1:0] b);
    bus1.load = ld; bus1.bin_in = b;
    bus2.load = ld; bus2.bin_in = b;
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic tick();
    bit r_s, l_s;
    int b_s, idx;
    logic [ND-1:0] ea;
    r_s = rst; l_s = bus1.load; b_s = int'(bus1.bin_in);
    @(posedge clk);
    #1;
    if (r_s) begin
      k = 0; busy = 0; pend_cnt = 0; ovf_cnt = 0;
      shown_val = 0; shown_ovf = 0; ovf_out = 0;
    end else begin
      k++;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin shown_val = pend_val; shown_ovf = pend_ovf; end
      end
      if (ovf_cnt > 0) begin
        ovf_cnt--;
        if (ovf_cnt == 0) ovf_out = pend_ovf;
      end
      if (busy > 0) busy--;
      else if (l_s) begin
        busy = BW + 1; pend_cnt = BW + 2; ovf_cnt = BW + 1;
        pend_val = b_s; pend_ovf = (b_s > 9999);
      end
    end
    chk("ready1", 32'(bus1.ready), 32'(busy == 0));
    chk("ready2", 32'(bus2.ready), 32'(busy == 0));
    chk("overflow1", 32'(bus1.overflow), 32'(ovf_out));
    chk("overflow2", 32'(bus2.overflow), 32'(ovf_out));
    ea = exp_an(k);
    chk("an1", 32'(an1), 32'(ea));
    chk("an2", 32'(an2), 32'(ea));
    chk("one_hot_cold", 32'($countones(~an1) <= 1), 32'd1);
    if (ea != '1) begin
      idx = 0;
      for (int j = 0; j < ND; j++) if (!ea[j]) idx = j;
      chk("seg1", 32'(seg1), 32'(exp_seg(shown_val, shown_ovf, idx, 1'b1)));
      chk("seg2", 32'(seg2), 32'(exp_seg(shown_val, shown_ovf, idx, 1'b0)));
      if (!an1[idx]) cap1[idx] = seg1;
      if (!an2[idx]) cap2[idx] = seg2;
    end
    if (!r_s && k >= 2) begin
      chk("ghost_direct_switch", 32'(prev_an != '1 && an1 != '1 && an1 != prev_an), 32'd0);
      chk("ghost_double_dark", 32'(prev_an == '1 && an1 == '1), 32'd0);
    end
    prev_an = an1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus1.ready !== 1'b1 && n < 40) begin tick(); n++; end
    if (bus1.ready !== 1'b1) begin
      n_checks++; n_errors++;
      $display("FAIL ready_timeout: got %0b, expected 1", bus1.ready);
    end
  endtask

  // Run one full scan period after the display settles and collect each digit's glyph.
  task automatic capture();
    tick();
    for (int i = 0; i < ND; i++) begin cap1[i] = 7'bx; cap2[i] = 7'bx; end
    repeat (ND * SD) tick();
  endtask

  // Load a value, measure the busy window and capture the resulting display.
  task automatic apply_load(input int val);
    int low;
    wait_ready();
    set_in(1'b1, BW'(val));
    tick();
    set_in(1'b0, '0);
    low = (bus1.ready === 1'b0) ? 1 : 0;
    for (int n = 0; n < 40 && bus1.ready === 1'b0; n++) begin
      tick();
      if (bus1.ready === 1'b0) low++;
    end
    chk("ready_low_cycles", 32'(low), 32'(BW + 1));
    wait_ready();
    capture();
  endtask

  initial begin
    glyph = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
              7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    tbl[0] = '{val: 1234,  ovf: 1'b0, s: {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}};
    tbl[1] = '{val: 7,     ovf: 1'b0, s: {7'b1111111, 7'b1111111, 7'b1111111, 7'b0001111}};
    tbl[2] = '{val: 10000, ovf: 1'b1, s: {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110}};
    tbl[3] = '{val: 42,    ovf: 1'b0, s: {7'b1111111, 7'b1111111, 7'b1001100, 7'b0010010}};
    tbl[4] = '{val: 0,     ovf: 1'b0, s: {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}};
    tbl[5] = '{val: 9999,  ovf: 1'b0, s: {7'b0000100, 7'b0000100, 7'b0000100, 7'b0000100}};
    tbl[6] = '{val: 16383, ovf: 1'b1, s: {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110}};
    prev_an = '1;
    k = 0; busy = 0; pend_cnt = 0; ovf_cnt = 0; pend_val = 0;
    shown_val = 0; shown_ovf = 0; ovf_out = 0; pend_ovf = 0;

    // reset state
    rst = 1'b1;
    set_in(1'b0, '0);
    repeat (3) tick();
    chk("rst_ready", 32'(bus1.ready), 32'd1);
    chk("rst_overflow", 32'(bus1.overflow), 32'd0);
    chk("rst_an", 32'(an1), 32'hF);
    chk("rst_seg", 32'(seg1), 32'h7F);
    rst = 1'b0;
    tick();
    chk("first_an", 32'(an1), 32'hE);
    chk("first_seg", 32'(seg1), 32'h01);

    // table of display values
    for (int t = 0; t < 7; t++) begin
      apply_load(tbl[t].val);
      chk("tbl_overflow", 32'(bus1.overflow), 32'(tbl[t].ovf));
      for (int i = 0; i < ND; i++) chk("tbl_digit", 32'(cap1[i]), 32'(tbl[t].s[i]));
    end

    // no leading-zero blanking variant shows zeros above a single digit
    apply_load(7);
    chk("nolz_d0", 32'(cap2[0]), 32'h0F);
    for (int i = 1; i < ND; i++) chk("nolz_upper", 32'(cap2[i]), 32'h01);

    // load while busy is dropped
    wait_ready();
    set_in(1'b1, BW'(500));
    tick();
    set_in(1'b0, '0);
    tick();
    set_in(1'b1, BW'(9));
    tick();
    set_in(1'b0, '0);
    wait_ready();
    capture();
    chk("busy_load_d0", 32'(cap1[0]), 32'h01);
    chk("busy_load_d1", 32'(cap1[1]), 32'h01);
    chk("busy_load_d2", 32'(cap1[2]), 32'h24);
    chk("busy_load_d3", 32'(cap1[3]), 32'h7F);

    // reset in the middle of a conversion of an out-of-range value
    set_in(1'b1, BW'(12345));
    tick();
    set_in(1'b0, '0);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_ready", 32'(bus1.ready), 32'd1);
    chk("abort_overflow", 32'(bus1.overflow), 32'd0);
    repeat (30) tick();
    capture();
    chk("abort_d0", 32'(cap1[0]), 32'h01);
    for (int i = 1; i < ND; i++) chk("abort_upper", 32'(cap1[i]), 32'h7F);

    // random loads at random times against the model (well over 100 scan periods)
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 11) == 0) begin
        if ($urandom_range(0, 1) == 0) set_in(1'b1, BW'($urandom_range(0, 9999)));
        else                           set_in(1'b1, BW'($urandom_range(0, 16383)));
      end else begin
        set_in(1'b0, BW'($urandom_range(0, 16383)));
      end
      tick();
    end
    set_in(1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
